lgs_core_sched: RTL and testbench

//  Round-robin scheduler that shares one flattened combinational benchmark core
//  (24-in / 21-out two-level logic, e.g. the lgsynth91 ttt2 netlist) between
//  N_REQ requesters. It registers the winning input vector onto the core,

---
 rtl/lgs_core_sched.sv | 98 +++++++++
 tb/tb_lgs_core_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lgs_core_sched.sv
// Round-robin scheduler sharing one combinational benchmark core between N_REQ
// requesters: accept, drive core_in, wait SETTLE_CYC, sample core_out, respond.
module lgs_core_sched #(
    parameter int N_REQ      = 4,
    parameter int IN_W       = 24,
    parameter int OUT_W      = 21,
    parameter int SETTLE_CYC = 2,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*IN_W-1:0]  req_data,
    output logic [IN_W-1:0]        core_in,
    input  logic [OUT_W-1:0]       core_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [OUT_W-1:0]       rsp_data,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt;
    logic [3:0]      cnt;
    logic [ID_W:0]   pick_r;
    logic            found;
    logic [ID_W-1:0] pick;

    // Scan downwards so the lowest offset from p (highest priority) is written last.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] v,
                                              input logic [ID_W-1:0]  p);
        int idx;
        rr_pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % N_REQ;
            if (v[idx]) rr_pick = {1'b1, ID_W'(idx)};
        end
    endfunction

    assign pick_r = rr_pick(req_valid, rr_ptr);
    assign found  = pick_r[ID_W];
    assign pick   = pick_r[ID_W-1:0];
    assign busy   = (state != IDLE);

    // The accept strobe is gated by rst_n so nothing looks accepted while in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && found) req_ready[pick] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt       <= '0;
            cnt       <= '0;
            core_in   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        core_in <= req_data[pick*IN_W +: IN_W];
                        gnt     <= pick;
                        cnt     <= 4'(SETTLE_CYC - 1);
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) state <= CAPTURE;
                    else             cnt   <= cnt - 4'd1;
                end
                CAPTURE: begin
                    rsp_data  <= core_out;
                    rsp_id    <= gnt;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lgs_core_sched.sv
// Directed + random bench for lgs_core_sched with a stand-in two-level core and
// a scoreboard of expected responses filled at each accept.
module tb_lgs_core_sched;

    localparam int N  = 4;
    localparam int IW = 24;
    localparam int OW = 21;

    typedef struct {
        int            id;
        logic [OW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*IW-1:0] req_data;
    logic [IW-1:0]   core_in;
    logic [OW-1:0]   core_out;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [OW-1:0]   rsp_data;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int nrsp   = 0;

    exp_t sb[$];
    int   glog_id[$];
    int   glog_cyc[$];

    function automatic logic [OW-1:0] core_f(input logic [IW-1:0] x);
        return (x[20:0] & ~x[23:3]) | (x[23:3] & {x[2:0], x[20:3]});
    endfunction

    function automatic logic [N-1:0] exp_oh(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    lgs_core_sched #(.N_REQ(N), .IN_W(IW), .OUT_W(OW), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .core_in(core_in), .core_out(core_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    assign core_out = core_f(core_in);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: grant model, scoreboard push/pop, hold and stall stability.
    int            mptr = 0;
    logic          acc = 1'b1, stall = 1'b0;
    logic [IW-1:0] pcore;
    logic [1:0]    pid;
    logic [OW-1:0] pdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            mptr  = 0;
            acc   = 1'b1;
            stall = 1'b0;
        end else begin
            int   g;
            exp_t e;
            chk("req_ready", 32'(req_ready), busy ? 32'd0 : 32'(exp_oh(req_valid, mptr)));
            if (!acc) chk("core_in_hold", 32'(core_in), 32'(pcore));
            if (stall) begin
                chk("stall_valid", 32'(rsp_valid), 32'd1);
                chk("stall_id", 32'(rsp_id), 32'(pid));
                chk("stall_data", 32'(rsp_data), 32'(pdata));
            end
            if (|req_ready) begin
                g = 0;
                for (int i = N - 1; i >= 0; i--) if (req_ready[i]) g = i;
                e.id   = g;
                e.data = core_f(req_data[g*IW +: IW]);
                sb.push_back(e);
                glog_id.push_back(g);
                glog_cyc.push_back(cyc);
            end
            if (rsp_valid && rsp_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    mptr = (e.id + 1) % N;
                    nrsp++;
                end
            end
            acc   = |req_ready;
            stall = rsp_valid && !rsp_ready;
            pcore = core_in;
            pid   = rsp_id;
            pdata = rsp_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]    sid;
        logic [OW-1:0] sdata;
        bit            done;
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_data = '0;

        // Reset state, then idle with no requests.
        repeat (3) tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_core_in", 32'(core_in), 32'd0);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        end

        // Single request from requester 2: latency and response content.
        req_data[2*IW +: IW] = 24'hA5A5A5;
        req_valid = 4'b0100; rsp_ready = 1'b1;
        #1 chk("t2_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("t2_ready_off", 32'(req_ready), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_core_in", 32'(core_in), 32'hA5A5A5);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("t2_latency", 32'(rsp_valid), 32'(k == 3));
        end
        chk("t2_id", 32'(rsp_id), 32'd2);
        chk("t2_data", 32'(rsp_data), 32'(core_f(24'hA5A5A5)));
        tick();
        chk("t2_done_valid", 32'(rsp_valid), 32'd0);
        chk("t2_done_busy", 32'(busy), 32'd0);

        // All requesting: rotation 0,1,2,3,0 five cycles apart.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        glog_id.delete(); glog_cyc.delete();
        req_data = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        req_valid = 4'b1111;
        repeat (21) tick();
        req_valid = 4'b0000;
        repeat (6) tick();
        chk("t3_ngrants", 32'(glog_id.size()), 32'd5);
        if (glog_id.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("t3_order", 32'(glog_id[i]), 32'(i % N));
            for (int i = 1; i < 5; i++) chk("t3_gap", 32'(glog_cyc[i] - glog_cyc[i-1]), 32'd5);
        end

        // Back-pressure: response held stable for 7 cycles, then regrant.
        rsp_ready = 1'b0;
        req_data[1*IW +: IW] = 24'h3C5A96;
        req_valid = 4'b0010;
        tick();
        repeat (3) tick();
        chk("t4_valid", 32'(rsp_valid), 32'd1);
        sid = rsp_id; sdata = rsp_data;
        chk("t4_id", 32'(sid), 32'd1);
        repeat (7) begin
            tick();
            chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t4_hold_id", 32'(rsp_id), 32'(sid));
            chk("t4_hold_data", 32'(rsp_data), 32'(sdata));
            chk("t4_no_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("t4_released", 32'(rsp_valid), 32'd0);
        chk("t4_regrant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        repeat (6) tick();

        // Reset during SETTLE aborts the transaction and clears the pointer.
        req_data[3*IW +: IW] = 24'h123456;
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0000;
        chk("t5_busy", 32'(busy), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_core_in", 32'(core_in), 32'd0);
        repeat (2) begin
            tick();
            chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        req_valid = 4'b1001;
        #1 chk("t5_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        repeat (6) tick();

        // Random traffic against the scoreboard.
        nrsp = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            req_valid = N'($urandom);
            req_data  = {$urandom(), $urandom(), $urandom()};
            rsp_ready = 1'($urandom_range(0, 1));
        end
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            tick();
            done = !busy && !rsp_valid;
        end
        chk("t6_drained", 32'(done), 32'd1);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);
        chk("t6_activity", 32'(nrsp > 500), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
